// File: rtl/text_geom_pkg.sv
// Shared geometry defaults and walker state encoding for the text-console cell walker.
// The walker's optional TEXT_SCROLL_EN build adds a row-scroll input.
package text_geom_pkg;

    localparam int DEF_SCREEN_WIDTH = 680;
    localparam int DEF_CHAR_WIDTH   = 20;
    localparam int DEF_CHAR_HEIGHT  = 30;
    localparam int DEF_TEXT_COLS    = 32;
    localparam int DEF_TEXT_ROWS    = 8;
    localparam int DEF_MAX_CHARS    = 240;
    localparam int DEF_ORIGIN_Y     = 240;
    localparam int DEF_ADDR_W       = 19;

    localparam int LOG2_COLS   = $clog2(DEF_TEXT_COLS);
    localparam int CELL_PIXELS = DEF_CHAR_WIDTH * DEF_CHAR_HEIGHT;
    // Jump from the last pixel of one cell row to the first pixel of the next.
    localparam int ROW_STEP    = DEF_SCREEN_WIDTH - DEF_CHAR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BASE = 2'd1,
        WALK = 2'd2
    } walk_state_t;

endpackage

// File: rtl/text_cell_base_calc.sv
// Maps a latched character index (and optional row scroll) to the cell's first pixel address.
// Also flags indices outside the populated part of the text region.
module text_cell_base_calc
    import text_geom_pkg::*;
#(
    parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
    parameter int CHAR_WIDTH   = DEF_CHAR_WIDTH,
    parameter int CHAR_HEIGHT  = DEF_CHAR_HEIGHT,
    parameter int TEXT_COLS    = DEF_TEXT_COLS,
    parameter int TEXT_ROWS    = DEF_TEXT_ROWS,
    parameter int MAX_CHARS    = DEF_MAX_CHARS,
    parameter int ORIGIN_Y     = DEF_ORIGIN_Y,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int ROW_BITS     = 3
)
(
    input  logic [31:0]         index,
    input  logic [ROW_BITS-1:0] scroll,
    output logic [ADDR_W-1:0]   base,
    output logic                oor
);

    localparam int COL_BITS = $clog2(TEXT_COLS);

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row_lo;
    logic [ROW_BITS:0]   row_sum;
    logic [ROW_BITS:0]   row_eff;

    assign oor    = (index >= 32'(MAX_CHARS));
    assign col    = index[COL_BITS-1:0];
    // Only rows below TEXT_ROWS matter; out-of-range indices never reach the walk.
    assign row_lo = index[COL_BITS +: ROW_BITS];

    assign row_sum = {1'b0, row_lo} + {1'b0, scroll};
    assign row_eff = (row_sum >= (ROW_BITS+1)'(TEXT_ROWS)) ? row_sum - (ROW_BITS+1)'(TEXT_ROWS)
                                                          : row_sum;

    assign base = (ADDR_W'(ORIGIN_Y) + ADDR_W'(row_eff) * ADDR_W'(CHAR_HEIGHT)) * ADDR_W'(SCREEN_WIDTH)
                + ADDR_W'(col) * ADDR_W'(CHAR_WIDTH);

endmodule

// File: rtl/text_cell_pixel_walker.sv
// Streams every frame-buffer pixel address of one text cell, row-major, one beat per handshake.
// Define TEXT_SCROLL_EN to add scroll_row, which rotates the cell row within the text region.
module text_cell_pixel_walker
    import text_geom_pkg::*;
#(
    parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
    parameter int CHAR_WIDTH   = DEF_CHAR_WIDTH,
    parameter int CHAR_HEIGHT  = DEF_CHAR_HEIGHT,
    parameter int TEXT_COLS    = DEF_TEXT_COLS,
    parameter int TEXT_ROWS    = DEF_TEXT_ROWS,
    parameter int MAX_CHARS    = DEF_MAX_CHARS,
    parameter int ORIGIN_Y     = DEF_ORIGIN_Y,
    parameter int ADDR_W       = DEF_ADDR_W,
    localparam int ROW_BITS    = (TEXT_ROWS > 1) ? $clog2(TEXT_ROWS) : 1
)
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_index,
`ifdef TEXT_SCROLL_EN
    input  logic [ROW_BITS-1:0] scroll_row,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_last,
    output logic                oor_err,
    output logic                busy,
    output walk_state_t         dbg_state
);

    // Handshakes: a transfer occurs on a rising clock edge where valid and ready are both high;
    // while valid is high and ready is low, the source holds its payload unchanged.

    localparam int X_BITS = (CHAR_WIDTH > 1) ? $clog2(CHAR_WIDTH) : 1;
    localparam int Y_BITS = (CHAR_HEIGHT > 1) ? $clog2(CHAR_HEIGHT) : 1;
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(CHAR_WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(CHAR_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(SCREEN_WIDTH - CHAR_WIDTH + 1);
    localparam longint REGION_LAST = (longint'(ORIGIN_Y) + longint'(TEXT_ROWS) * CHAR_HEIGHT - 1) * SCREEN_WIDTH
                                   + longint'(TEXT_COLS) * CHAR_WIDTH - 1;

    if (REGION_LAST >= (longint'(1) << ADDR_W)) begin : g_addr_overflow
        $error("text_cell_pixel_walker: text region exceeds ADDR_W address space");
    end
    if (MAX_CHARS > TEXT_COLS * TEXT_ROWS) begin : g_chars_overflow
        $error("text_cell_pixel_walker: MAX_CHARS larger than the text grid");
    end

    walk_state_t         state;
    logic [31:0]         idx_q;
    logic [ROW_BITS-1:0] scroll_q;
    logic [ROW_BITS-1:0] scroll_in;
    logic [X_BITS-1:0]   x_q;
    logic [Y_BITS-1:0]   y_q;
    logic [ADDR_W-1:0]   base_addr;
    logic                base_oor;

`ifdef TEXT_SCROLL_EN
    assign scroll_in = scroll_row;
`else
    assign scroll_in = '0;
`endif

    text_cell_base_calc #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .CHAR_WIDTH   (CHAR_WIDTH),
        .CHAR_HEIGHT  (CHAR_HEIGHT),
        .TEXT_COLS    (TEXT_COLS),
        .TEXT_ROWS    (TEXT_ROWS),
        .MAX_CHARS    (MAX_CHARS),
        .ORIGIN_Y     (ORIGIN_Y),
        .ADDR_W       (ADDR_W),
        .ROW_BITS     (ROW_BITS)
    ) u_base (
        .index  (idx_q),
        .scroll (scroll_q),
        .base   (base_addr),
        .oor    (base_oor)
    );

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            oor_err   <= 1'b0;
            idx_q     <= '0;
            scroll_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            oor_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        idx_q     <= req_index;
                        scroll_q  <= scroll_in;
                        req_ready <= 1'b0;
                        state     <= BASE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BASE: begin
                    if (base_oor) begin
                        oor_err   <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_addr  <= base_addr;
                        out_valid <= 1'b1;
                        out_last  <= (CHAR_WIDTH == 1) && (CHAR_HEIGHT == 1);
                        x_q       <= '0;
                        y_q       <= '0;
                        state     <= WALK;
                    end
                end
                WALK: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else if (x_q == X_LAST) begin
                            // Wrap to the start of the next line inside the cell.
                            x_q      <= '0;
                            y_q      <= y_q + Y_BITS'(1);
                            out_addr <= out_addr + STEP;
                            out_last <= (CHAR_WIDTH == 1) && ((y_q + Y_BITS'(1)) == Y_LAST);
                        end else begin
                            x_q      <= x_q + X_BITS'(1);
                            out_addr <= out_addr + ADDR_W'(1);
                            out_last <= ((x_q + X_BITS'(1)) == X_LAST) && (y_q == Y_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_cell_pixel_walker.sv
// Bench for text_cell_pixel_walker: randomized requests and out_ready stalls checked by a
// scoreboard fed from an arithmetic cell model; honours TEXT_SCROLL_EN when defined.
module tb_text_cell_pixel_walker;
    import text_geom_pkg::*;

    localparam int SW = 680, CW = 20, CH = 30, COLS = 32, ROWS = 8, MAXC = 240, OY = 240, AW = 19;
    localparam int W = AW + 1;
`ifdef TEXT_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_index = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          oor_err;
    logic          busy;
    walk_state_t   dbg_state;
`ifdef TEXT_SCROLL_EN
    logic [2:0]    scroll_row = '0;
`endif

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    text_cell_pixel_walker dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_index (req_index),
`ifdef TEXT_SCROLL_EN
        .scroll_row(scroll_row),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .oor_err   (oor_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_q[$];
    int            oor_q[$];
    bit            stall_mode = 1'b0;
    int            acc_cyc = 0;
    int            beat_cnt = 0;
    int            oor_seen = 0;
    bit            got_first = 1'b0;
    int            first_valid_cyc = 0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] beat20_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every pixel of the cell, row by row, from plain geometry.
    task automatic push_cell(input logic [31:0] idx, input int scroll);
        longint row, col, base;
        if (idx >= MAXC) begin
            oor_q.push_back(cyc);
            return;
        end
        row  = ((idx / COLS) + scroll) % ROWS;
        col  = idx % COLS;
        base = (OY + row * CH) * SW + col * CW;
        for (int y = 0; y < CH; y++)
            for (int x = 0; x < CW; x++)
                exp_q.push_back({(x == CW - 1 && y == CH - 1), AW'(base + y * SW + x)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [31:0] idx, input int scroll);
        bit done = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_index = idx;
`ifdef TEXT_SCROLL_EN
        scroll_row = 3'(scroll);
`endif
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clock);
            if (req_ready && resetn) begin
                beat_cnt  = 0;
                got_first = 1'b0;
                acc_cyc   = cyc;
                push_cell(idx, SCROLL ? scroll : 0);
                done = 1'b1;
            end
            @(posedge clock);
        end
        check("request_accepted", done, 1);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && oor_q.size() == 0 && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", ok, 1);
        repeat (2) @(negedge clock);
    endtask

    always @(posedge clock) begin
        #1 out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitor ----------------
    bit           prev_stall = 1'b0;
    bit           last_seen = 1'b0;
    bit           prev_oor = 1'b0;
    logic [W-1:0] held = '0;
    logic [W-1:0] e;
    int           a;

    always @(negedge clock) begin
        if (!resetn) begin
            prev_stall = 1'b0;
            last_seen  = 1'b0;
            prev_oor   = 1'b0;
        end else begin
            if (last_seen) begin
                check("ready_after_last", req_ready, 1);
                last_seen = 1'b0;
            end
            if (prev_stall) begin
                check("valid_held_in_stall", out_valid, 1);
                check("payload_held_in_stall", {out_last, out_addr}, held);
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                check("ready_low_in_walk", req_ready, 0);
                if (!got_first) begin
                    got_first       = 1'b1;
                    first_addr      = out_addr;
                    first_valid_cyc = cyc;
                end
                if (out_ready) begin
                    check("beat_queued", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat", {out_last, out_addr}, e);
                    end
                    if (beat_cnt == 20) beat20_addr = out_addr;
                    beat_cnt++;
                    if (out_last) begin
                        last_addr = out_addr;
                        last_seen = 1'b1;
                    end
                end else begin
                    prev_stall = 1'b1;
                    held       = {out_last, out_addr};
                end
            end
            if (oor_err) begin
                check("oor_single_cycle", prev_oor, 0);
                check("oor_queued", oor_q.size() > 0, 1);
                if (oor_q.size() > 0) begin
                    a = oor_q.pop_front();
                    check("oor_latency", cyc - a, 2);
                end
                check("oor_back_idle", req_ready, 1);
                check("oor_no_beat", out_valid, 0);
                oor_seen++;
            end
            prev_oor = oor_err;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int oor_before;
        bit ok;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_last", out_last, 0);
        check("rst_oor_err", oor_err, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("ready_low_before_edge", req_ready, 0);
        @(negedge clock);
        check("ready_after_reset", req_ready, 1);

        // Index 0, no stalls.
        send_req(32'd0, 0);
        wait_idle();
        check("idx0_first", first_addr, 163200);
        check("idx0_beat20", beat20_addr, 163880);
        check("idx0_last", last_addr, 182939);
        check("idx0_beats", beat_cnt, 600);
        check("idx0_latency", first_valid_cyc - acc_cyc, 2);

        send_req(32'd33, 0);
        wait_idle();
        check("idx33_first", first_addr, 183620);

        // Out-of-range indices produce a pulse and no beats.
        oor_before = oor_seen;
        send_req(32'd240, 0);
        wait_idle();
        check("idx240_beats", beat_cnt, 0);
        send_req(32'hFFFF_FFFF, 0);
        wait_idle();
        check("idxmax_beats", beat_cnt, 0);
        check("oor_pulses", oor_seen - oor_before, 2);

        // Last cell under random back-pressure.
        stall_mode = 1'b1;
        send_req(32'd239, 0);
        wait_idle();
        stall_mode = 1'b0;
        check("idx239_first", first_addr, 306300);
        check("idx239_last", last_addr, 326039);
        check("idx239_beats", beat_cnt, 600);

        // Asynchronous reset in the middle of a stream.
        send_req(32'd0, 0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (beat_cnt >= 100) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_beat_100", ok, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_addr", out_addr, 0);
        check("async_out_last", out_last, 0);
        check("async_req_ready", req_ready, 0);
        check("async_busy", busy, 0);
        exp_q.delete();
        oor_q.delete();
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (4) @(negedge clock);
        check("no_resume", out_valid, 0);
        send_req(32'd5, 0);
        wait_idle();
        check("idx5_first", first_addr, 163300);

`ifdef TEXT_SCROLL_EN
        send_req(32'd224, 1);
        wait_idle();
        check("scroll_wrap_first", first_addr, 163200);
`endif

        // Randomized requests, scroll values and stall patterns.
        for (int n = 0; n < 16; n++) begin
            logic [31:0] idx;
            int          sc;
            idx        = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MAXC - 1));
            sc         = $urandom_range(0, ROWS - 1);
            stall_mode = 1'($urandom_range(0, 1));
            send_req(idx, sc);
            wait_idle();
        end
        stall_mode = 1'b0;

        check("beat_queue_empty", exp_q.size(), 0);
        check("oor_queue_empty", oor_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
